aes_key_expand_seq: RTL and testbench

Sequential AES key-schedule engine. Pops one cipher key from an input FIFO and emits every round key, one 128-bit round key per accepted write, into an output FIFO. It is the parametrised successor of the single-step key-expansion stages. It supports AES-128 and AES-256 and owns the Rcon sequencing and round counting. It sits between the key FIFO and the round-key FIFO that feeds the cipher datapath.

---
 rtl/aes_key_pkg.sv | 45 ++++
 rtl/aes_key_expand_seq_if.sv | 36 +++
 rtl/aes_sub_word.sv | 14 +
 rtl/aes_key_expand_seq.sv | 114 +++++++++++
 tb/tb_aes_key_expand_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types, S-box table and word helpers for the AES key-schedule engine
package aes_key_pkg;

    typedef logic [31:0]  key_word_t;
    typedef logic [127:0] round_key_t;
    typedef enum logic {IDLE, EMIT} key_exp_state_e;

    localparam int NR_AES128 = 10;
    localparam int NR_AES256 = 14;

    // Entry 0 sits in the top byte so the literal reads in the usual row order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic key_word_t bswap32(input key_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Word j with byte 4j in the most significant position.
    function automatic key_word_t rk_word(input round_key_t rk, input logic [1:0] j);
        return bswap32(rk[{j, 5'b00000} +: 32]);
    endfunction

    function automatic round_key_t rk_pack(input key_word_t w0, input key_word_t w1,
                                           input key_word_t w2, input key_word_t w3);
        return {bswap32(w3), bswap32(w2), bswap32(w1), bswap32(w0)};
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// rtl/aes_key_expand_seq_if.sv - key FIFO / round-key FIFO bundle; AES_KEY_EXP_ROUND_TAG_EN adds round tags
interface aes_key_expand_seq_if import aes_key_pkg::*; #(
    parameter int KEY_BITS = 128,
    parameter int RND_W    = 4
);
    logic [KEY_BITS-1:0] in_key;
    logic                in_key_rd;
    logic                in_key_empty;
    round_key_t          out_key;
    logic                out_key_wr;
    logic                out_key_full;
    logic                busy;

`ifdef AES_KEY_EXP_ROUND_TAG_EN
    logic [RND_W-1:0]    out_round;
    logic                out_last;

    modport master (
        input  in_key, in_key_empty, out_key_full,
        output in_key_rd, out_key, out_key_wr, busy, out_round, out_last
    );
    modport slave (
        output in_key, in_key_empty, out_key_full,
        input  in_key_rd, out_key, out_key_wr, busy, out_round, out_last
    );
`else
    modport master (
        input  in_key, in_key_empty, out_key_full,
        output in_key_rd, out_key, out_key_wr, busy
    );
    modport slave (
        output in_key, in_key_empty, out_key_full,
        input  in_key_rd, out_key, out_key_wr, busy
    );
`endif
endinterface

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - combinational SubWord with optional RotWord, one S-box per byte lane
module aes_sub_word import aes_key_pkg::*; (
    input  key_word_t in_word,
    input  logic      rot,
    output key_word_t out_word
);
    key_word_t rot_word;

    assign rot_word = rot ? {in_word[23:0], in_word[31:24]} : in_word;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign out_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
    end
endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/256 key schedule; AES_KEY_EXP_ROUND_TAG_EN adds out_round/out_last
module aes_key_expand_seq import aes_key_pkg::*; #(
    parameter int KEY_BITS = 128,
    parameter int RND_W    = 4
) (
    input logic                  clock,
    input logic                  reset,
    aes_key_expand_seq_if.master kif
);
    localparam int NR   = (KEY_BITS == 256) ? NR_AES256 : NR_AES128;
    localparam bit WIDE = (KEY_BITS == 256);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand_seq: KEY_BITS must be 128 or 256");
    end

    key_exp_state_e   state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [7:0]       rcon_q, rcon_d;
    round_key_t       prev_q, prev_d;
    round_key_t       cur_q, cur_d;
    logic             busy_q, busy_d;

    logic       rd, wr, rot, last_rnd;
    key_word_t  last_word, sw_out, mix;
    key_word_t  n0, n1, n2, n3;
    round_key_t base;

    assign rd       = (state_q == IDLE) && !kif.in_key_empty && !reset;
    assign wr       = (state_q == EMIT) && !kif.out_key_full && !reset;
    assign last_rnd = (rnd_q == RND_W'(NR));
    // AES-256 rotates and applies Rcon only when producing an even round key (odd rnd).
    assign rot       = !WIDE || rnd_q[0];
    assign last_word = rk_word(cur_q, 2'd3);

    aes_sub_word u_sub_word (
        .in_word  (last_word),
        .rot      (rot),
        .out_word (sw_out)
    );

    always_comb begin
        base    = WIDE ? prev_q : cur_q;
        mix     = sw_out ^ (rot ? {rcon_q, 24'h000000} : 32'h0);
        n0      = rk_word(base, 2'd0) ^ mix;
        n1      = rk_word(base, 2'd1) ^ n0;
        n2      = rk_word(base, 2'd2) ^ n1;
        n3      = rk_word(base, 2'd3) ^ n2;
        state_d = state_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    cur_d   = kif.in_key[127:0];
                    prev_d  = kif.in_key[KEY_BITS-1 -: 128];
                    rnd_d   = '0;
                    rcon_d  = 8'h01;
                    state_d = EMIT;
                    busy_d  = 1'b1;
                end
            end
            EMIT: begin
                if (wr) begin
                    rnd_d = rnd_q + RND_W'(1);
                    // For AES-256 the second key half was parked in prev at pop time.
                    if (WIDE && rnd_q == '0) begin
                        cur_d  = prev_q;
                        prev_d = cur_q;
                    end else begin
                        prev_d = cur_q;
                        cur_d  = rk_pack(n0, n1, n2, n3);
                        if (rot) rcon_d = xtime(rcon_q);
                    end
                    if (last_rnd) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            rcon_q  <= 8'h01;
            prev_q  <= '0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
        end
    end

    assign kif.in_key_rd  = rd;
    assign kif.out_key_wr = wr;
    assign kif.out_key    = cur_q;
    assign kif.busy       = busy_q;
`ifdef AES_KEY_EXP_ROUND_TAG_EN
    assign kif.out_round  = rnd_q;
    assign kif.out_last   = wr && last_rnd;
`endif
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - directed/random bench for aes_key_expand_seq against a FIPS-197 word-array model
module tb_aes_key_expand_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   sel   = 1'b0;

    always #5 clock = ~clock;

    aes_key_expand_seq_if #(.KEY_BITS(128)) ka ();
    aes_key_expand_seq_if #(.KEY_BITS(256)) kb ();

    aes_key_expand_seq #(.KEY_BITS(128)) dut_a (.clock(clock), .reset(reset), .kif(ka));
    aes_key_expand_seq #(.KEY_BITS(256)) dut_b (.clock(clock), .reset(reset), .kif(kb));

    logic         s_rd, s_wr, s_busy;
    logic [127:0] s_key;
    assign s_rd   = sel ? kb.in_key_rd  : ka.in_key_rd;
    assign s_wr   = sel ? kb.out_key_wr : ka.out_key_wr;
    assign s_busy = sel ? kb.busy       : ka.busy;
    assign s_key  = sel ? kb.out_key    : ka.out_key;
`ifdef AES_KEY_EXP_ROUND_TAG_EN
    logic [3:0] s_round;
    logic       s_last;
    assign s_round = sel ? kb.out_round : ka.out_round;
    assign s_last  = sel ? kb.out_last  : ka.out_last;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0]   sb [256];
    logic [127:0] ref_rk [15];
    logic [255:0] keyq [$];
    logic [127:0] cap [$];
    int           nrd;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0]  inv;
        logic [15:0] t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            t = {inv, inv};
            sb[x] = inv ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [255:0] brev(input logic [255:0] v, input int nb);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = v[8*(nb-1-i) +: 8];
        return r;
    endfunction

    task automatic ref_expand(input logic [255:0] kp, input bit big);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = big ? 8 : 4;
        nr = big ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = {kp[32*i +: 8], kp[32*i+8 +: 8], kp[32*i+16 +: 8], kp[32*i+24 +: 8]};
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    ref_rk[r][32*j + 8*k +: 8] = w[4*r+j][31-8*k -: 8];
    endtask

    task automatic drive(input bit big, input logic [255:0] key, input bit empty, input bit full);
        ka.in_key       = big ? 128'h0 : key[127:0];
        ka.in_key_empty = big ? 1'b1 : empty;
        ka.out_key_full = big ? 1'b0 : full;
        kb.in_key       = big ? key : 256'h0;
        kb.in_key_empty = big ? empty : 1'b1;
        kb.out_key_full = big ? full : 1'b0;
    endtask

    // Plays the key FIFO and round-key FIFO; entered and left on a falling edge with the engine idle.
    task automatic run_keys(input bit big, input int stall_pct, input int max_wr, input int min_cyc);
        logic [127:0] expq [$];
        logic [127:0] key_now;
        bit m_idle, full, exp_rd, exp_wr, rd_now;
        int rnd, nr, cyc, nwr;
        m_idle = 1'b1;
        rnd = 0; cyc = 0; nwr = 0;
        nr  = big ? 14 : 10;
        sel = big;
        cap.delete();
        nrd = 0;
        while (cyc < 2000) begin
            if (cyc >= min_cyc && keyq.size() == 0 && m_idle) break;
            if (max_wr >= 0 && nwr == max_wr) break;
            full = ($urandom_range(0, 99) < stall_pct);
            drive(big, (keyq.size() != 0) ? keyq[0] : 256'h0, keyq.size() == 0, full);
            #1;
            exp_rd = m_idle && keyq.size() != 0;
            exp_wr = !m_idle && !full;
            check("in_key_rd", s_rd, exp_rd);
            check("busy", s_busy, !m_idle);
            check("out_key_wr", s_wr, exp_wr);
            if (!m_idle) check("out_key", s_key, expq[0]);
`ifdef AES_KEY_EXP_ROUND_TAG_EN
            if (exp_wr) begin
                check("out_round", s_round, rnd);
                check("out_last", s_last, rnd == nr);
            end
`endif
            rd_now  = s_rd;
            key_now = s_key;
            @(posedge clock);
            if (rd_now) nrd++;
            if (exp_rd) begin
                ref_expand(keyq.pop_front(), big);
                for (int r = 0; r <= nr; r++) expq.push_back(ref_rk[r]);
                m_idle = 1'b0;
                rnd = 0;
            end else if (exp_wr) begin
                cap.push_back(key_now);
                void'(expq.pop_front());
                rnd++;
                nwr++;
                if (rnd == nr + 1) m_idle = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        check("timeout", cyc < 2000, 1'b1);
    endtask

    function automatic logic [255:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] k128, k256, k2;
        build_sbox();
        k128 = brev(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
        k256 = brev(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);

        drive(1'b0, k128, 1'b0, 1'b0);
        kb.in_key_empty = 1'b0;
        #3;
        check("rst_rd_a", ka.in_key_rd, 1'b0);
        check("rst_wr_a", ka.out_key_wr, 1'b0);
        check("rst_key_a", ka.out_key, 128'h0);
        check("rst_busy_a", ka.busy, 1'b0);
        check("rst_rd_b", kb.in_key_rd, 1'b0);
        check("rst_key_b", kb.out_key, 128'h0);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_keys(1'b0, 0, -1, 20);

        keyq.push_back(k128);
        run_keys(1'b0, 0, -1, 0);
        check("a128_count", cap.size(), 11);
        check("a128_w1", cap[1], brev(256'ha0fafe1788542cb123a339392a6c7605, 16));
        check("a128_w10", cap[10], brev(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16));
        check("a128_rd_once", nrd, 1);

        keyq.push_back(k256);
        run_keys(1'b1, 0, -1, 0);
        check("a256_count", cap.size(), 15);
        check("a256_w2", cap[2], brev(256'h9ba354118e6925afa51a8b5f2067fcde, 16));
        check("a256_w14", cap[14], brev(256'hfe4890d1e6188d0b046df344706c631e, 16));

        keyq.push_back(k128);
        run_keys(1'b0, 50, -1, 0);
        check("stall_count", cap.size(), 11);
        check("stall_w1", cap[1], brev(256'ha0fafe1788542cb123a339392a6c7605, 16));
        check("stall_w10", cap[10], brev(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16));

        keyq.push_back(k128);
        keyq.push_back(rnd_key());
        run_keys(1'b0, 0, -1, 0);
        check("b2b_rd", nrd, 2);
        check("b2b_count", cap.size(), 22);

        keyq.push_back(rnd_key());
        keyq.push_back(rnd_key());
        run_keys(1'b1, 30, -1, 0);
        check("rand256_count", cap.size(), 30);

        k2 = rnd_key();
        keyq.push_back(k128);
        keyq.push_back(k2);
        run_keys(1'b0, 0, 4, 0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_key", ka.out_key, 128'h0);
        check("arst_wr", ka.out_key_wr, 1'b0);
        check("arst_busy", ka.busy, 1'b0);
        check("arst_rd", ka.in_key_rd, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        run_keys(1'b0, 0, -1, 0);
        check("arst_fresh_w0", cap[0], k2[127:0]);
        check("arst_fresh_count", cap.size(), 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
